// File: rtl/cc_mux21_feeder.sv
// rtl/cc_mux21_feeder.sv - select and data-word feeder for the 2:1 multiplexer
//
// Purpose:
//   Holds the two registered data words presented to the multiplexer and
//   generates its select line. Select either alternates between the two
//   channels with a programmable dwell or follows a manual force override.
//   Every output is registered so the multiplexer sees glitch-free inputs.
//
// Optional feature (macro CC_MUX21FEED_SHADOW_EN):
//   Loads aimed at the channel the multiplexer is currently passing are held
//   in a per-channel shadow register and copied to the output register on
//   the edge that deselects that channel. Undefined: loads update at once.
//
// Ports:
//   CC_MUX21FEED_CLOCK_50      in   system clock, rising edge
//   CC_MUX21FEED_RESET_InLow   in   synchronous active-low reset
//   CC_MUX21FEED_enable_In     in   1 = alternate channels, 0 = hold select
//   CC_MUX21FEED_force_In      in   1 = manual select override
//   CC_MUX21FEED_forceSel_In   in   channel while forced (0 = data1, 1 = data2)
//   CC_MUX21FEED_load1_In      in   capture data1_InBUS
//   CC_MUX21FEED_data1_InBUS   in   channel-1 data
//   CC_MUX21FEED_load2_In      in   capture data2_InBUS
//   CC_MUX21FEED_data2_InBUS   in   channel-2 data
//   CC_MUX21FEED_select_Out    out  multiplexer select
//   CC_MUX21FEED_data1_OutBUS  out  registered channel 1
//   CC_MUX21FEED_data2_OutBUS  out  registered channel 2
//   CC_MUX21FEED_switch_Out    out  one-cycle pulse when select changes
module cc_mux21_feeder #(
  parameter int MUX21FEED_DATAWIDTH = 8,
  parameter int MUX21FEED_DWELL     = 4,
  parameter int MUX21FEED_CNTWIDTH  = 8
) (
  input  logic                           CC_MUX21FEED_CLOCK_50,
  input  logic                           CC_MUX21FEED_RESET_InLow,
  input  logic                           CC_MUX21FEED_enable_In,
  input  logic                           CC_MUX21FEED_force_In,
  input  logic                           CC_MUX21FEED_forceSel_In,
  input  logic                           CC_MUX21FEED_load1_In,
  input  logic [MUX21FEED_DATAWIDTH-1:0] CC_MUX21FEED_data1_InBUS,
  input  logic                           CC_MUX21FEED_load2_In,
  input  logic [MUX21FEED_DATAWIDTH-1:0] CC_MUX21FEED_data2_InBUS,
  output logic                           CC_MUX21FEED_select_Out,
  output logic [MUX21FEED_DATAWIDTH-1:0] CC_MUX21FEED_data1_OutBUS,
  output logic [MUX21FEED_DATAWIDTH-1:0] CC_MUX21FEED_data2_OutBUS,
  output logic                           CC_MUX21FEED_switch_Out
);

  typedef enum logic [1:0] {ST_IDLE, ST_CH1, ST_CH2, ST_FORCED} state_t;

  // Counter value on the last cycle of a dwell.
  localparam logic [MUX21FEED_CNTWIDTH-1:0] CNT_LAST =
    MUX21FEED_CNTWIDTH'(MUX21FEED_DWELL - 1);

  state_t                           state_q, state_d;
  logic [MUX21FEED_CNTWIDTH-1:0]    cnt_q, cnt_d;
  logic                             sel_q, sel_d;
  logic                             sw_q, sw_d;
  logic [MUX21FEED_DATAWIDTH-1:0]   d1_q, d1_d;
  logic [MUX21FEED_DATAWIDTH-1:0]   d2_q, d2_d;

  // Select state machine. Force wins over enable in every state; sel_d is
  // the select value the multiplexer will see after this edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (CC_MUX21FEED_force_In) begin
      state_d = ST_FORCED;
      sel_d   = CC_MUX21FEED_forceSel_In;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (CC_MUX21FEED_enable_In) begin
            state_d = ST_CH1;
            cnt_d   = '0;
          end
        end
        ST_CH1, ST_CH2: begin
          if (CC_MUX21FEED_enable_In) begin
            if (cnt_q == CNT_LAST) begin
              state_d = (state_q == ST_CH1) ? ST_CH2 : ST_CH1;
              sel_d   = ~sel_q;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        ST_FORCED: begin
          // Force released: resume alternation on whichever channel was forced.
          state_d = sel_q ? ST_CH2 : ST_CH1;
          cnt_d   = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign sw_d = sel_d ^ sel_q;

`ifdef CC_MUX21FEED_SHADOW_EN
  logic [MUX21FEED_DATAWIDTH-1:0] sh1_q, sh1_d, sh2_q, sh2_d;
  logic                           pend1_q, pend1_d, pend2_q, pend2_d;
  logic                           act1, act2, leave1, leave2;

  // A channel is "live" while the multiplexer is passing it outside IDLE;
  // it is left on the edge where the registered select moves away from it.
  assign act1   = (state_q != ST_IDLE) && !sel_q;
  assign act2   = (state_q != ST_IDLE) &&  sel_q;
  assign leave1 = act1 &&  sel_d;
  assign leave2 = act2 && !sel_d;

  always_comb begin
    d1_d    = d1_q;
    d2_d    = d2_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    // A load arriving on the deselect edge itself is the newest word, so it
    // goes straight to the output instead of the shadow.
    if (CC_MUX21FEED_load1_In && act1 && !leave1) begin
      sh1_d   = CC_MUX21FEED_data1_InBUS;
      pend1_d = 1'b1;
    end else if (CC_MUX21FEED_load1_In) begin
      d1_d = CC_MUX21FEED_data1_InBUS;
    end else if (leave1 && pend1_q) begin
      d1_d = sh1_q;
    end
    if (leave1) pend1_d = 1'b0;

    if (CC_MUX21FEED_load2_In && act2 && !leave2) begin
      sh2_d   = CC_MUX21FEED_data2_InBUS;
      pend2_d = 1'b1;
    end else if (CC_MUX21FEED_load2_In) begin
      d2_d = CC_MUX21FEED_data2_InBUS;
    end else if (leave2 && pend2_q) begin
      d2_d = sh2_q;
    end
    if (leave2) pend2_d = 1'b0;
  end

  always_ff @(posedge CC_MUX21FEED_CLOCK_50) begin
    if (!CC_MUX21FEED_RESET_InLow) begin
      sh1_q   <= '0;
      sh2_q   <= '0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
    end else begin
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
    end
  end
`else
  always_comb begin
    d1_d = CC_MUX21FEED_load1_In ? CC_MUX21FEED_data1_InBUS : d1_q;
    d2_d = CC_MUX21FEED_load2_In ? CC_MUX21FEED_data2_InBUS : d2_q;
  end
`endif

  always_ff @(posedge CC_MUX21FEED_CLOCK_50) begin
    if (!CC_MUX21FEED_RESET_InLow) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      sw_q    <= 1'b0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      sw_q    <= sw_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign CC_MUX21FEED_select_Out   = sel_q;
  assign CC_MUX21FEED_switch_Out   = sw_q;
  assign CC_MUX21FEED_data1_OutBUS = d1_q;
  assign CC_MUX21FEED_data2_OutBUS = d2_q;

endmodule

// File: tb/tb_cc_mux21_feeder.sv
// tb/tb_cc_mux21_feeder.sv - self-checking bench for cc_mux21_feeder
module tb_cc_mux21_feeder;
  localparam int DW    = 8;
  localparam int DWELL = 4;

  logic          clk = 1'b0;
  logic          rstn, en, frc, fsel, ld1, ld2;
  logic [DW-1:0] d1_in, d2_in;
  logic          sel, sw;
  logic [DW-1:0] d1_out, d2_out;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = alternating, 2 = forced.
  // m_rem counts the cycles still left in the current channel's dwell.
  int            m_mode, m_rem;
  logic          m_sel, m_sw;
  logic [DW-1:0] m_d1, m_d2, m_s1, m_s2;
  logic          m_p1, m_p2;

  cc_mux21_feeder #(
    .MUX21FEED_DATAWIDTH(DW),
    .MUX21FEED_DWELL    (DWELL),
    .MUX21FEED_CNTWIDTH (8)
  ) dut (
    .CC_MUX21FEED_CLOCK_50    (clk),
    .CC_MUX21FEED_RESET_InLow (rstn),
    .CC_MUX21FEED_enable_In   (en),
    .CC_MUX21FEED_force_In    (frc),
    .CC_MUX21FEED_forceSel_In (fsel),
    .CC_MUX21FEED_load1_In    (ld1),
    .CC_MUX21FEED_data1_InBUS (d1_in),
    .CC_MUX21FEED_load2_In    (ld2),
    .CC_MUX21FEED_data2_InBUS (d2_in),
    .CC_MUX21FEED_select_Out  (sel),
    .CC_MUX21FEED_data1_OutBUS(d1_out),
    .CC_MUX21FEED_data2_OutBUS(d2_out),
    .CC_MUX21FEED_switch_Out  (sw)
  );

  always #5 clk = ~clk;

  // Advance the model on the current inputs, then let the DUT take the edge.
  task automatic tick();
    int   old_mode;
    logic prev, act1, act2, leave1, leave2;
    old_mode = m_mode;
    prev     = m_sel;
    if (!rstn) begin
      m_mode = 0; m_rem = 0; m_sel = 0; m_sw = 0;
      m_d1 = '0; m_d2 = '0; m_s1 = '0; m_s2 = '0; m_p1 = 0; m_p2 = 0;
    end else begin
      if (frc) begin
        m_mode = 2; m_sel = fsel;
      end else if (m_mode == 2 || (m_mode == 0 && en)) begin
        m_mode = 1; m_rem = DWELL;
      end else if (m_mode == 1 && en) begin
        if (m_rem == 1) begin m_sel = ~m_sel; m_rem = DWELL; end
        else m_rem = m_rem - 1;
      end
      m_sw = (m_sel != prev);
`ifdef CC_MUX21FEED_SHADOW_EN
      act1 = (old_mode != 0) && !prev;  leave1 = act1 &&  m_sel;
      act2 = (old_mode != 0) &&  prev;  leave2 = act2 && !m_sel;
      if (ld1 && act1 && !leave1) begin m_s1 = d1_in; m_p1 = 1; end
      else if (ld1) m_d1 = d1_in;
      else if (leave1 && m_p1) m_d1 = m_s1;
      if (leave1) m_p1 = 0;
      if (ld2 && act2 && !leave2) begin m_s2 = d2_in; m_p2 = 1; end
      else if (ld2) m_d2 = d2_in;
      else if (leave2 && m_p2) m_d2 = m_s2;
      if (leave2) m_p2 = 0;
`else
      act1 = 0; act2 = 0; leave1 = 0; leave2 = 0;
      if (ld1) m_d1 = d1_in;
      if (ld2) m_d2 = d2_in;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; frc = 0; fsel = 0; ld1 = 0; ld2 = 0;
    d1_in = '0; d2_in = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    tick();
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0;
    for (int i = 0; i < 3; i++) begin
      en = 1; frc = 1'($urandom); fsel = 1'($urandom);
      ld1 = 1; ld2 = 1; d1_in = 8'($urandom | 1); d2_in = 8'($urandom | 1);
      tick();
      checks++;
      if ({sel, sw, d1_out, d2_out} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
        errors++;
        $display("FAIL reset[%0d]: sel=%b sw=%b d1=%h d2=%h, expected all zero", i, sel, sw, d1_out, d2_out);
      end
    end
    idle_inputs();
    rstn = 1;
  endtask

  task automatic test_alternate();
    logic exp_sel, exp_sw;
    do_reset();
    en = 1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      exp_sel = (((n - 1) / DWELL) % 2) == 1;
      exp_sw  = (n == 5) || (n == 9);
      checks++;
      if (sel !== exp_sel || sw !== exp_sw) begin
        errors++;
        $display("FAIL alternate cycle %0d: sel=%b sw=%b, expected sel=%b sw=%b", n, sel, sw, exp_sel, exp_sw);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    en = 1;
    for (int i = 0; i < 3; i++) tick();
    en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (sel !== 1'b0 || sw !== 1'b0) begin
        errors++;
        $display("FAIL pause hold %0d: sel=%b sw=%b, expected sel=0 sw=0", i, sel, sw);
      end
    end
    en = 1;
    tick();
    checks++;
    if (sel !== 1'b0 || sw !== 1'b0) begin
      errors++;
      $display("FAIL pause resume1: sel=%b sw=%b, expected sel=0 sw=0", sel, sw);
    end
    tick();
    checks++;
    if (sel !== 1'b1 || sw !== 1'b1) begin
      errors++;
      $display("FAIL pause resume2: sel=%b sw=%b, expected sel=1 sw=1", sel, sw);
    end
  endtask

  task automatic test_force();
    // {force, forceSel, expected select, expected switch} per cycle
    logic [3:0] steps [9] = '{4'b1111, 4'b1001, 4'b1111, 4'b1001,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0011};
    logic [3:0] st;
    do_reset();
    en = 1;
    tick(); tick();
    for (int i = 0; i < 9; i++) begin
      st = steps[i];
      frc = st[3]; fsel = st[2];
      tick();
      checks++;
      if (sel !== st[1] || sw !== st[0]) begin
        errors++;
        $display("FAIL force step %0d: sel=%b sw=%b, expected sel=%b sw=%b", i, sel, sw, st[1], st[0]);
      end
    end
    frc = 0;
  endtask

  task automatic test_loads();
    logic          exp_sel;
    logic [DW-1:0] exp_d1;
    do_reset();
    en = 1;
    tick();
    for (int n = 2; n <= 9; n++) begin
      ld1 = (n == 2); ld2 = (n == 2);
      d1_in = (n == 2) ? 8'hA5 : 8'($urandom);
      d2_in = (n == 2) ? 8'h3C : 8'($urandom);
      tick();
      exp_sel = (((n - 1) / DWELL) % 2) == 1;
`ifdef CC_MUX21FEED_SHADOW_EN
      exp_d1 = (n >= 5) ? 8'hA5 : 8'h00;
`else
      exp_d1 = 8'hA5;
`endif
      checks++;
      if (sel !== exp_sel || d1_out !== exp_d1 || d2_out !== 8'h3C) begin
        errors++;
        $display("FAIL loads cycle %0d: sel=%b d1=%h d2=%h, expected sel=%b d1=%h d2=3c", n, sel, d1_out, d2_out, exp_sel, exp_d1);
      end
    end
    ld1 = 0; ld2 = 0;
  endtask

  task automatic test_midreset();
    do_reset();
    en = 1; ld1 = 1; ld2 = 1;
    d1_in = 8'($urandom | 8'h01); d2_in = 8'($urandom | 8'h01);
    tick();
    ld1 = 0; ld2 = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (sel !== 1'b1 || d1_out === 8'h00 || d2_out === 8'h00) begin
      errors++;
      $display("FAIL midreset setup: sel=%b d1=%h d2=%h, expected sel=1 and nonzero data", sel, d1_out, d2_out);
    end
    rstn = 0;
    tick();
    rstn = 1; en = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({sel, sw, d1_out, d2_out} !== {1'b0, 1'b0, 8'h00, 8'h00}) begin
        errors++;
        $display("FAIL midreset idle %0d: sel=%b sw=%b d1=%h d2=%h, expected all zero", i, sel, sw, d1_out, d2_out);
      end
      tick();
    end
  endtask

  task automatic test_shadow_load();
    logic [DW-1:0] exp_d1;
    do_reset();
    en = 1;
    tick();
    for (int n = 2; n <= 6; n++) begin
      ld1 = (n == 2); d1_in = 8'h55;
      tick();
`ifdef CC_MUX21FEED_SHADOW_EN
      exp_d1 = (n >= 5) ? 8'h55 : 8'h00;
`else
      exp_d1 = 8'h55;
`endif
      checks++;
      if (d1_out !== exp_d1) begin
        errors++;
        $display("FAIL shadow_load cycle %0d: d1=%h, expected %h", n, d1_out, exp_d1);
      end
    end
    ld1 = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      rstn  = ($urandom % 60) != 0;
      en    = ($urandom % 4) != 0;
      frc   = ($urandom % 10) == 0;
      fsel  = 1'($urandom);
      ld1   = ($urandom % 3) == 0;
      ld2   = ($urandom % 3) == 0;
      d1_in = 8'($urandom);
      d2_in = 8'($urandom);
      tick();
      checks++;
      if ({sel, sw, d1_out, d2_out} !== {m_sel, m_sw, m_d1, m_d2}) begin
        errors++;
        $display("FAIL random %0d: sel=%b sw=%b d1=%h d2=%h, expected sel=%b sw=%b d1=%h d2=%h",
                 i, sel, sw, d1_out, d2_out, m_sel, m_sw, m_d1, m_d2);
      end
    end
    rstn = 1;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    m_mode = 0; m_rem = 0; m_sel = 0; m_sw = 0;
    m_d1 = '0; m_d2 = '0; m_s1 = '0; m_s2 = '0; m_p1 = 0; m_p2 = 0;
    #2;
    test_reset();
    test_alternate();
    test_pause();
    test_force();
    test_loads();
    test_midreset();
    test_shadow_load();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
